// File: rtl/vga_timing_gen_if.sv
// Timing bus between vga_timing_gen (master) and its pixel consumer (slave).
interface vga_timing_gen_if #(
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned FRAME_W = 8
);
  logic               pix_en;
  logic [CNT_W-1:0]   hpos;
  logic [CNT_W-1:0]   vpos;
  logic               display_on;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;
  logic               hsync_o;
  logic               vsync_o;
  logic               de_o;
  logic [5:0]         tp_rgb;

  modport master (
    input  pix_en,
    output hpos, vpos, display_on, line_start, frame_start, frame_cnt,
           hsync_o, vsync_o, de_o, tp_rgb
  );

  modport slave (
    output pix_en,
    input  hpos, vpos, display_on, line_start, frame_start, frame_cnt,
           hsync_o, vsync_o, de_o, tp_rgb
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel enable and a delay-matched sync/de pipeline.
// Define VGA_TESTPAT_EN to build the 8-colour-bar test pattern on tp_rgb.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned FRAME_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned XW      = CNT_W + 1;
  localparam int unsigned PW      = 9;

  // One extra bit so a limit equal to 2^CNT_W still compares correctly.
  localparam logic [CNT_W:0] H_ACT_X = XW'(H_ACTIVE);
  localparam logic [CNT_W:0] H_SS_X  = XW'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] H_SE_X  = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] V_ACT_X = XW'(V_ACTIVE);
  localparam logic [CNT_W:0] V_SS_X  = XW'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] V_SE_X  = XW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  localparam logic [PW-1:0] IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0, 6'b00_0000};

  if (H_SYNC == 0 || V_SYNC == 0 || H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_chk_zero
    $fatal(1, "vga_timing_gen: H_SYNC, V_SYNC, H_ACTIVE and V_ACTIVE must be > 0");
  end
  if (64'(H_TOTAL) > (64'(1) << CNT_W) || 64'(V_TOTAL) > (64'(1) << CNT_W)) begin : g_chk_cnt
    $fatal(1, "vga_timing_gen: line/frame totals do not fit in CNT_W bits");
  end
  if (PIPE_DEPTH > 8) begin : g_chk_pipe
    $fatal(1, "vga_timing_gen: PIPE_DEPTH must be 0..8");
  end

  logic [CNT_W-1:0]   hpos_q;
  logic [CNT_W-1:0]   vpos_q;
  logic [FRAME_W-1:0] frame_q;

  // Pixel/line/frame counters, advancing only on enabled clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      frame_q <= '0;
    end else if (bus.pix_en) begin
      if (hpos_q == H_LAST) begin
        hpos_q <= '0;
        if (vpos_q == V_LAST) begin
          vpos_q  <= '0;
          frame_q <= frame_q + FRAME_W'(1);
        end else begin
          vpos_q <= vpos_q + CNT_W'(1);
        end
      end else begin
        hpos_q <= hpos_q + CNT_W'(1);
      end
    end
  end

  logic [CNT_W:0] hx;
  logic [CNT_W:0] vx;
  logic           de_raw;
  logic           hsync_raw;
  logic           vsync_raw;
  logic [5:0]     tp_raw;

  assign hx        = {1'b0, hpos_q};
  assign vx        = {1'b0, vpos_q};
  assign de_raw    = (hx < H_ACT_X) && (vx < V_ACT_X);
  assign hsync_raw = (hx >= H_SS_X && hx < H_SE_X) ? SYNC_POL : ~SYNC_POL;
  assign vsync_raw = (vx >= V_SS_X && vx < V_SE_X) ? SYNC_POL : ~SYNC_POL;

`ifdef VGA_TESTPAT_EN
  localparam bit H_POW2 = (H_ACTIVE >= 8) && ((H_ACTIVE & (H_ACTIVE - 1)) == 0);

  logic [2:0] bar;

  if (H_POW2) begin : g_bar_slice
    localparam int unsigned BAR_LSB = $clog2(H_ACTIVE) - 3;
    assign bar = hpos_q[BAR_LSB +: 3];
  end else begin : g_bar_chain
    // Bar k starts at ceil(k*H_ACTIVE/8), so hpos*8/H_ACTIVE equals the thresholds passed.
    always_comb begin
      bar = 3'd0;
      for (int i = 1; i < 8; i++) begin
        if (hx >= XW'((i * H_ACTIVE + 7) / 8)) bar = bar + 3'd1;
      end
    end
  end

  assign tp_raw = de_raw ? {bar[2], bar[2], bar[1], bar[1], bar[0], bar[0]} : 6'b00_0000;
`else
  assign tp_raw = 6'b00_0000;
`endif

  logic [PW-1:0] raw;
  logic [PW-1:0] dly;

  assign raw = {hsync_raw, vsync_raw, de_raw, tp_raw};

  if (PIPE_DEPTH == 0) begin : g_nopipe
    assign dly = raw;
  end else begin : g_pipe
    logic [PW-1:0] stage [PIPE_DEPTH];

    // Delay line keeping sync/de/pattern aligned with a multi-cycle renderer.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE_DEPTH; i++) stage[i] <= IDLE;
      end else if (bus.pix_en) begin
        stage[0] <= raw;
        for (int i = 1; i < PIPE_DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dly = stage[PIPE_DEPTH-1];
  end

  assign bus.hpos        = hpos_q;
  assign bus.vpos        = vpos_q;
  assign bus.frame_cnt   = frame_q;
  assign bus.display_on  = de_raw;
  // Strobes are masked during reset so they read 0 while rst_n is low.
  assign bus.line_start  = rst_n && bus.pix_en && (hpos_q == '0);
  assign bus.frame_start = rst_n && bus.pix_en && (hpos_q == '0) && (vpos_q == '0);
  assign bus.hsync_o     = dly[8];
  assign bus.vsync_o     = dly[7];
  assign bus.de_o        = dly[6];
  assign bus.tp_rgb      = dly[5:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus a tiny 7x5 instance for frame-level behaviour.
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic rst_s_n;

  int vectors;
  int miscompares;

`ifdef VGA_TESTPAT_EN
  localparam logic [5:0] TP_BAR1 = 6'b000011;
  localparam logic [5:0] TP_BAR2 = 6'b001100;
`else
  localparam logic [5:0] TP_BAR1 = 6'b000000;
  localparam logic [5:0] TP_BAR2 = 6'b000000;
`endif

  vga_timing_gen_if #(.CNT_W(10), .FRAME_W(8)) bus ();
  vga_timing_gen_if #(.CNT_W(4),  .FRAME_W(2)) bus_s ();

  vga_timing_gen u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .PIPE_DEPTH(0), .CNT_W(4), .FRAME_W(2)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_s_n),
    .bus   (bus_s.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Alternating enable: n enabled clocks spread over 2n clocks, ends with pix_en=0.
  task automatic toggle(input int n);
    repeat (n) begin
      bus.pix_en = 1'b1;
      @(posedge clk); #1;
      bus.pix_en = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    rst_s_n     = 1'b0;
    bus.pix_en  = 1'b1;
    bus_s.pix_en = 1'b1;

    // Reset values with pix_en held high
    step(3);
    chk("rst_hpos", 32'(bus.hpos), 0);
    chk("rst_vpos", 32'(bus.vpos), 0);
    chk("rst_frame", 32'(bus.frame_cnt), 0);
    chk("rst_hsync_o", 32'(bus.hsync_o), 1);
    chk("rst_vsync_o", 32'(bus.vsync_o), 1);
    chk("rst_de_o", 32'(bus.de_o), 0);
    chk("rst_tp", 32'(bus.tp_rgb), 0);
    chk("rst_line_start", 32'(bus.line_start), 0);
    chk("rst_frame_start", 32'(bus.frame_start), 0);

    rst_n = 1'b1;
    #1;
    chk("rel_line_start", 32'(bus.line_start), 1);
    chk("rel_frame_start", 32'(bus.frame_start), 1);
    chk("rel_display_on", 32'(bus.display_on), 1);

    // Asynchronous reset in the middle of a line
    step(300);
    chk("mid_hpos", 32'(bus.hpos), 300);
    chk("mid_de_o", 32'(bus.de_o), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_hpos", 32'(bus.hpos), 0);
    chk("arst_hsync_o", 32'(bus.hsync_o), 1);
    chk("arst_vsync_o", 32'(bus.vsync_o), 1);
    chk("arst_de_o", 32'(bus.de_o), 0);
    step(2);
    chk("arst_hold_hpos", 32'(bus.hpos), 0);
    rst_n = 1'b1;
    step(1);
    chk("restart_hpos", 32'(bus.hpos), 1);
    chk("restart_vpos", 32'(bus.vpos), 0);

    // Active-video edge and 2-stage de delay
    step(638);
    chk("h639_display_on", 32'(bus.display_on), 1);
    step(1);
    chk("h640_display_on", 32'(bus.display_on), 0);
    chk("h640_de_o", 32'(bus.de_o), 1);
    step(2);
    chk("h642_de_o", 32'(bus.de_o), 0);
    chk("h642_tp", 32'(bus.tp_rgb), 0);

    // hsync window 656..751 seen two pixels later on hsync_o
    step(13);
    chk("h655_hsync_o", 32'(bus.hsync_o), 1);
    step(1);
    chk("h656_hsync_o", 32'(bus.hsync_o), 1);
    step(2);
    chk("h658_hsync_o", 32'(bus.hsync_o), 0);
    step(95);
    chk("h753_hsync_o", 32'(bus.hsync_o), 0);
    step(1);
    chk("h754_hsync_o", 32'(bus.hsync_o), 1);

    // Line wrap after 800 pixels
    step(45);
    chk("h799_hpos", 32'(bus.hpos), 799);
    chk("h799_vpos", 32'(bus.vpos), 0);
    step(1);
    chk("wrap_hpos", 32'(bus.hpos), 0);
    chk("wrap_vpos", 32'(bus.vpos), 1);
    chk("wrap_line_start", 32'(bus.line_start), 1);
    chk("wrap_frame_start", 32'(bus.frame_start), 0);
    step(1);
    chk("h1_line_start", 32'(bus.line_start), 0);
    step(1);
    chk("v1h2_de_o", 32'(bus.de_o), 1);

    // Test-pattern bars 1 and 2, aligned with de_o
    step(80);
    chk("bar1_tp", 32'(bus.tp_rgb), 32'(TP_BAR1));
    step(79);
    chk("bar1_end_tp", 32'(bus.tp_rgb), 32'(TP_BAR1));
    step(1);
    chk("bar2_tp", 32'(bus.tp_rgb), 32'(TP_BAR2));

    // pix_en toggling 1,0,1,0
    toggle(5);
    chk("tog_hpos", 32'(bus.hpos), 167);
    step(3);
    chk("tog_hold_hpos", 32'(bus.hpos), 167);
    toggle(473);
    chk("tog_h640", 32'(bus.hpos), 640);
    chk("tog_h640_de_o", 32'(bus.de_o), 1);
    toggle(2);
    chk("tog_h642_de_o", 32'(bus.de_o), 0);
    toggle(157);
    chk("tog_h799", 32'(bus.hpos), 799);
    toggle(1);
    chk("tog_wrap_hpos", 32'(bus.hpos), 0);
    chk("tog_wrap_vpos", 32'(bus.vpos), 2);
    chk("tog_ls_gated", 32'(bus.line_start), 0);
    bus.pix_en = 1'b1;
    #1;
    chk("tog_ls_enabled", 32'(bus.line_start), 1);

    // Small configuration: 7 pixels x 5 lines, PIPE_DEPTH=0, FRAME_W=2
    step(1);
    rst_s_n = 1'b1;
    #1;
    chk("s_hpos0", 32'(bus_s.hpos), 0);
    chk("s_frame_start0", 32'(bus_s.frame_start), 1);
    chk("s_frame_cnt0", 32'(bus_s.frame_cnt), 0);
    chk("s_hsync_h0", 32'(bus_s.hsync_o), 1);
    step(1);
    chk("s_h1_de_o", 32'(bus_s.de_o), 1);
    chk("s_h1_tp", 32'(bus_s.tp_rgb), 32'(TP_BAR2));
    step(4);
    chk("s_h5_hsync_o", 32'(bus_s.hsync_o), 0);
    step(1);
    chk("s_h6_hsync_o", 32'(bus_s.hsync_o), 1);
    chk("s_h6_de_o", 32'(bus_s.de_o), 0);
    chk("s_h6_tp", 32'(bus_s.tp_rgb), 0);
    step(1);
    chk("s_v1_vpos", 32'(bus_s.vpos), 1);
    chk("s_v1_line_start", 32'(bus_s.line_start), 1);
    step(14);
    chk("s_v3_vpos", 32'(bus_s.vpos), 3);
    chk("s_v3_vsync_o", 32'(bus_s.vsync_o), 0);
    chk("s_v3_de_o", 32'(bus_s.de_o), 0);
    step(7);
    chk("s_v4_vsync_o", 32'(bus_s.vsync_o), 1);
    step(6);
    chk("s_pre_frame_cnt", 32'(bus_s.frame_cnt), 0);
    step(1);
    chk("s_frame_cnt1", 32'(bus_s.frame_cnt), 1);
    chk("s_frame_start1", 32'(bus_s.frame_start), 1);
    step(1);
    chk("s_frame_start_off", 32'(bus_s.frame_start), 0);
    step(34);
    chk("s_frame_cnt2", 32'(bus_s.frame_cnt), 2);
    step(35);
    chk("s_frame_cnt3", 32'(bus_s.frame_cnt), 3);
    step(35);
    chk("s_frame_cnt_wrap", 32'(bus_s.frame_cnt), 0);
    chk("s_wrap_vpos", 32'(bus_s.vpos), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
